// File: rtl/df_module_perf_monitor.sv
// Per-channel performance monitor for HLS ap_ctrl handshakes.
// Saturating counters per channel, read back through a one-cycle register port.
module df_module_perf_monitor #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    output logic              any_busy,
    output logic              frozen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [CNT_W-1:0] lat_q   [NUM_CH];
    logic [CNT_W-1:0] lat_d   [NUM_CH];
    logic [CNT_W-1:0] busy_q  [NUM_CH];
    logic [CNT_W-1:0] busy_d  [NUM_CH];
    logic [CNT_W-1:0] stall_q [NUM_CH];
    logic [CNT_W-1:0] stall_d [NUM_CH];
    logic [CNT_W-1:0] start_q [NUM_CH];
    logic [CNT_W-1:0] start_d [NUM_CH];
    logic [CNT_W-1:0] done_q  [NUM_CH];
    logic [CNT_W-1:0] done_d  [NUM_CH];
    logic [CNT_W-1:0] ready_q [NUM_CH];
    logic [CNT_W-1:0] ready_d [NUM_CH];
    logic [CNT_W-1:0] last_q  [NUM_CH];
    logic [CNT_W-1:0] last_d  [NUM_CH];
    logic [CNT_W-1:0] max_q   [NUM_CH];
    logic [CNT_W-1:0] max_d   [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              frozen_q, frozen_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              rd_err_q, rd_err_d;
    logic              any_busy_q, any_busy_d;
    logic              cnt_en_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Returns {overflow_attempt, next_value}.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v, input logic inc);
        return {inc & (&v), (inc ? sat_inc(v) : v)};
    endfunction

    assign cnt_en_c = enable & ~frozen_q;

    // Channel FSMs, latency tracking and counter updates.
    always_comb begin : ch_next
        logic             inc_busy, inc_stall, inc_start, inc_done;
        logic             o_busy, o_stall, o_start, o_done, o_ready;
        logic [CNT_W-1:0] lat_nxt;
        any_busy_d = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            inc_busy   = 1'b0;
            inc_stall  = 1'b0;
            inc_start  = 1'b0;
            inc_done   = 1'b0;
            lat_nxt    = sat_inc(lat_q[i]);
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            last_d[i]  = last_q[i];
            max_d[i]   = max_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (ap_start[i]) begin
                        state_d[i] = ST_BUSY;
                        lat_d[i]   = CNT_W'(1);
                        inc_start  = 1'b1;
                    end
                end
                ST_BUSY: begin
                    inc_busy = 1'b1;
                    if (!ap_done[i]) begin
                        lat_d[i] = lat_nxt;
                    end else begin
                        last_d[i] = lat_nxt;
                        if (lat_nxt > max_q[i]) max_d[i] = lat_nxt;
                        if (ap_continue[i]) begin
                            inc_done = 1'b1;
                            if (ap_start[i]) begin
                                lat_d[i]  = CNT_W'(1);
                                inc_start = 1'b1;
                            end else begin
                                state_d[i] = ST_IDLE;
                            end
                        end else begin
                            state_d[i] = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ap_continue[i]) begin
                        inc_done   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end else begin
                        inc_stall = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            {o_busy,  busy_d[i]}  = bump(busy_q[i],  cnt_en_c & inc_busy);
            {o_stall, stall_d[i]} = bump(stall_q[i], cnt_en_c & inc_stall);
            {o_start, start_d[i]} = bump(start_q[i], cnt_en_c & inc_start);
            {o_done,  done_d[i]}  = bump(done_q[i],  cnt_en_c & inc_done);
            {o_ready, ready_d[i]} = bump(ready_q[i], cnt_en_c & ap_ready[i]);
            ovf_d[i] = ovf_q[i] | o_busy | o_stall | o_start | o_done | o_ready;
            // Clear has priority over same-cycle increments; FSM and lat_run keep running.
            if (clear) begin
                busy_d[i]  = '0;
                stall_d[i] = '0;
                start_d[i] = '0;
                done_d[i]  = '0;
                ready_d[i] = '0;
                last_d[i]  = '0;
                max_d[i]   = '0;
                ovf_d[i]   = 1'b0;
            end
            any_busy_d = any_busy_d | (state_d[i] != ST_IDLE);
        end
    end

    assign frozen_d = finish | (frozen_q & ~clear);

    // Read mux: snapshot of pre-edge values; out-of-range channel answers zero with error.
    always_comb begin : rd_next
        logic [CNT_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_field)
                    3'd0:    sel = busy_q[i];
                    3'd1:    sel = stall_q[i];
                    3'd2:    sel = start_q[i];
                    3'd3:    sel = done_q[i];
                    3'd4:    sel = ready_q[i];
                    3'd5:    sel = last_q[i];
                    3'd6:    sel = max_q[i];
                    default: sel = CNT_W'({frozen_q, ovf_q[i], state_q[i]});
                endcase
            end
        end
        rd_valid_d = rd_en;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_err_d  = (32'(rd_ch) >= NUM_CH);
            rd_data_d = rd_err_d ? '0 : sel;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= ST_IDLE;
                lat_q[i]   <= '0;
                busy_q[i]  <= '0;
                stall_q[i] <= '0;
                start_q[i] <= '0;
                done_q[i]  <= '0;
                ready_q[i] <= '0;
                last_q[i]  <= '0;
                max_q[i]   <= '0;
            end
            ovf_q      <= '0;
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            any_busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
                busy_q[i]  <= busy_d[i];
                stall_q[i] <= stall_d[i];
                start_q[i] <= start_d[i];
                done_q[i]  <= done_d[i];
                ready_q[i] <= ready_d[i];
                last_q[i]  <= last_d[i];
                max_q[i]   <= max_d[i];
            end
            ovf_q      <= ovf_d;
            frozen_q   <= frozen_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign any_busy = any_busy_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_df_module_perf_monitor.sv
// Directed bench for df_module_perf_monitor (NUM_CH=5, CNT_W=8); read
// responses are checked against a scoreboard queue filled when reads are issued.
module tb_df_module_perf_monitor;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned CNT_W  = 8;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              clear;
    logic              finish;
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [2:0]        rd_ch;
    logic [2:0]        rd_field;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_err;
    logic              any_busy;
    logic              frozen;

    typedef struct {
        logic [CNT_W-1:0] data;
        logic             err;
        int               id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    df_module_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .any_busy(any_busy), .frozen(frozen)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int ch, input int f, input logic [CNT_W-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.id   = ch * 8 + f;
        rd_en    = 1'b1;
        rd_ch    = 3'(ch);
        rd_field = 3'(f);
        sb.push_back(x);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rd_all(input int ch,
                          input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] s,
                          input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] d,
                          input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] ll,
                          input logic [CNT_W-1:0] ml, input logic [CNT_W-1:0] stat);
        rd(ch, 0, b, 1'b0);
        rd(ch, 1, s, 1'b0);
        rd(ch, 2, st, 1'b0);
        rd(ch, 3, d, 1'b0);
        rd(ch, 4, r, 1'b0);
        rd(ch, 5, ll, 1'b0);
        rd(ch, 6, ml, 1'b0);
        rd(ch, 7, stat, 1'b0);
        tick();
    endtask

    // One transaction of latency len (start at t0, done at t0+len-1).
    task automatic txn(input int ch, input int len);
        ap_start[ch] = 1'b1;
        ap_ready[ch] = 1'b1;
        tick();
        ap_start[ch] = 1'b0;
        ap_ready[ch] = 1'b0;
        repeat (len - 2) tick();
        ap_done[ch] = 1'b1;
        tick();
        ap_done[ch] = 1'b0;
    endtask

    // Scoreboard consumer.
    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_unexpected_valid", 32'(rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rd_data ch%0d f%0d", e.id / 8, e.id % 8), 32'(rd_data), 32'(e.data));
                check($sformatf("rd_err ch%0d f%0d", e.id / 8, e.id % 8), 32'(rd_err), 32'(e.err));
            end
        end
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        clear       = 1'b0;
        finish      = 1'b0;
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '1;
        rd_en       = 1'b0;
        rd_ch       = '0;
        rd_field    = '0;
        repeat (2) tick();
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_any_busy", 32'(any_busy), 32'd0);
        check("rst_frozen", 32'(frozen), 32'd0);
        reset = 1'b1;
        tick();
        rd_all(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single transaction, latency 5
        txn(0, 5);
        check("t1_any_busy", 32'(any_busy), 32'd0);
        rd_all(0, 4, 0, 1, 1, 1, 5, 5, 0);

        // Stall in WAIT for four cycles
        ap_start[2] = 1'b1;
        ap_ready[2] = 1'b1;
        tick();
        ap_start[2] = 1'b0;
        ap_ready[2] = 1'b0;
        repeat (2) tick();
        ap_done[2]     = 1'b1;
        ap_continue[2] = 1'b0;
        tick();
        ap_done[2] = 1'b0;
        check("t2_any_busy_wait", 32'(any_busy), 32'd1);
        rd(2, 7, 8'd2, 1'b0);
        repeat (3) tick();
        ap_continue[2] = 1'b1;
        tick();
        check("t2_any_busy_idle", 32'(any_busy), 32'd0);
        rd_all(2, 3, 4, 1, 1, 1, 4, 4, 0);

        // Back-to-back restarts: 6, 3, 9
        ap_start[1] = 1'b1;
        ap_ready[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0;
        ap_ready[1] = 1'b0;
        repeat (4) tick();
        ap_done[1]  = 1'b1;
        ap_start[1] = 1'b1;
        ap_ready[1] = 1'b1;
        tick();
        ap_done[1]  = 1'b0;
        ap_start[1] = 1'b0;
        ap_ready[1] = 1'b0;
        check("t3_busy_after_restart1", 32'(any_busy), 32'd1);
        tick();
        ap_done[1]  = 1'b1;
        ap_start[1] = 1'b1;
        ap_ready[1] = 1'b1;
        tick();
        ap_done[1]  = 1'b0;
        ap_start[1] = 1'b0;
        ap_ready[1] = 1'b0;
        check("t3_busy_after_restart2", 32'(any_busy), 32'd1);
        repeat (7) tick();
        ap_done[1] = 1'b1;
        tick();
        ap_done[1] = 1'b0;
        check("t3_any_busy_end", 32'(any_busy), 32'd0);
        rd_all(1, 15, 0, 3, 3, 3, 9, 9, 0);

        // Freeze, then more traffic must not move ch0 counters
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("t5_frozen_set", 32'(frozen), 32'd1);
        repeat (20) txn(0, 5);
        check("t5_frozen_held", 32'(frozen), 32'd1);
        rd_all(0, 4, 0, 1, 1, 1, 5, 5, 8'h08);
        rd(7, 0, 8'd0, 1'b1);
        rd(5, 6, 8'd0, 1'b1);
        rd(4, 7, 8'h08, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_frozen_cleared", 32'(frozen), 32'd0);
        rd(0, 0, 8'd0, 1'b0);
        rd(0, 7, 8'd0, 1'b0);
        tick();

        // Saturation with CNT_W=8
        ap_start[3] = 1'b1;
        tick();
        ap_start[3] = 1'b0;
        repeat (299) tick();
        rd(3, 0, 8'd255, 1'b0);
        rd(3, 7, 8'h05, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rd(3, 0, 8'd0, 1'b0);
        rd(3, 7, 8'h01, 1'b0);
        rd(3, 2, 8'd0, 1'b0);
        ap_done[3] = 1'b1;
        tick();
        ap_done[3] = 1'b0;
        rd(3, 5, 8'd255, 1'b0);
        rd(3, 6, 8'd255, 1'b0);
        rd(3, 7, 8'h00, 1'b0);
        tick();

        // Async reset mid-BUSY, then an orphan ap_done
        ap_start[4] = 1'b1;
        tick();
        ap_start[4] = 1'b0;
        repeat (3) tick();
        rd(4, 2, 8'd1, 1'b0);
        tick();
        check("t6_busy_before_reset", 32'(any_busy), 32'd1);
        check("t6_rd_data_before_reset", 32'(rd_data), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_rst_rd_data", 32'(rd_data), 32'd0);
        check("t6_rst_rd_err", 32'(rd_err), 32'd0);
        check("t6_rst_any_busy", 32'(any_busy), 32'd0);
        check("t6_rst_frozen", 32'(frozen), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        ap_done[4] = 1'b1;
        tick();
        ap_done[4] = 1'b0;
        check("t6_orphan_done_idle", 32'(any_busy), 32'd0);
        rd_all(4, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
